// File: rtl/nemo_pkg.sv
// Shared types and constants for the NEMO SPI serf.
// Register addresses, FSM states, sample snapshot struct and setup value.
package nemo_pkg;

  localparam logic [6:0] A_INT_CFG = 7'h0D;
  localparam logic [6:0] A_WHOAMI  = 7'h0F;
  localparam logic [6:0] A_PTCH_L  = 7'h22;
  localparam logic [6:0] A_PTCH_H  = 7'h23;
  localparam logic [6:0] A_ROLL_L  = 7'h24;
  localparam logic [6:0] A_ROLL_H  = 7'h25;
  localparam logic [6:0] A_YAW_L   = 7'h26;
  localparam logic [6:0] A_YAW_H   = 7'h27;
  localparam logic [6:0] A_AX_L    = 7'h28;
  localparam logic [6:0] A_AX_H    = 7'h29;
  localparam logic [6:0] A_AY_L    = 7'h2A;
  localparam logic [6:0] A_AY_H    = 7'h2B;

  localparam logic [7:0] SETUP_VAL = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [15:0] ptch;
    logic [15:0] roll;
    logic [15:0] yaw;
    logic [15:0] ax;
    logic [15:0] ay;
  } snap_t;

  function automatic snap_t mk_snap(input logic [15:0] c);
    snap_t s;
    s.ptch = c;
    s.roll = ~c;
    s.yaw  = {c[14:0], 1'b0};
    s.ax   = c ^ 16'h5A5A;
    s.ay   = 16'h0000 - c;
    return s;
  endfunction

endpackage

// File: rtl/spi_serf_shift.sv
// SPI front end: input synchronizers, edge detect, bit counter, rx/tx shifters.
// Ports: clk, rst, SS_n/SCLK/MOSI in; load/load_data/tx_clr/tx_act control; edges, bit_cnt, rx, rx_nxt, miso out.
module spi_serf_shift
  import nemo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_clr,
  input  logic       tx_act,
  output logic       ss_fall,
  output logic       ss_rise,
  output logic       sclk_rise,
  output logic [3:0] bit_cnt,
  output logic [7:0] rx,
  output logic [7:0] rx_nxt,
  output logic       miso
);

  logic [1:0] ss_q;
  logic [1:0] sclk_q;
  logic [1:0] mosi_q;
  logic       ss_d;
  logic       sclk_d;
  logic       sclk_fall;
  logic [7:0] tx;

  assign ss_fall   = ss_d & ~ss_q[1];
  assign ss_rise   = ~ss_d & ss_q[1];
  assign sclk_rise = ~sclk_d & sclk_q[1];
  assign sclk_fall = sclk_d & ~sclk_q[1];
  // Byte as it will look after the current rise is shifted in.
  assign rx_nxt    = {rx[6:0], mosi_q[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_q    <= 2'b11;
      ss_d    <= 1'b1;
      sclk_q  <= 2'b00;
      sclk_d  <= 1'b0;
      mosi_q  <= 2'b00;
      bit_cnt <= 4'd0;
      rx      <= 8'h00;
      tx      <= 8'h00;
      miso    <= 1'b0;
    end else begin
      ss_q   <= {ss_q[0], SS_n};
      sclk_q <= {sclk_q[0], SCLK};
      mosi_q <= {mosi_q[0], MOSI};
      ss_d   <= ss_q[1];
      sclk_d <= sclk_q[1];
      if (ss_fall) begin
        bit_cnt <= 4'd0;
      end else if (sclk_rise && !ss_q[1]) begin
        bit_cnt <= bit_cnt + 4'd1;
        rx      <= rx_nxt;
      end
      if (load) begin
        tx <= load_data;
      end else if (tx_act && sclk_fall) begin
        tx <= {tx[6:0], 1'b0};
      end
      if (tx_clr) begin
        miso <= 1'b0;
      end else if (tx_act && sclk_fall) begin
        miso <= tx[7];
      end
    end
  end

endmodule

// File: rtl/spi_nemo_serf.sv
// NEMO SPI serf top: frame FSM, register file and periodic sample generator.
// Ports: clk, rst, SS_n, SCLK, MOSI in; MISO, INT, NEMO_setup out. Macro NEMO_WHOAMI_EN maps WHO_AM_I.
module spi_nemo_serf
  import nemo_pkg::*;
#(
  parameter int         INT_PERIOD = 50000,
  parameter logic [7:0] WHOAMI_VAL = 8'h6A
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic INT,
  output logic NEMO_setup
);

  localparam int PW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
  localparam logic [PW-1:0] PER_MAX = PW'(INT_PERIOD - 1);

  state_t        state;
  logic          rw;
  logic [6:0]    addr;
  logic          done_first;
  logic [7:0]    int_cfg;
  logic [PW-1:0] per_cnt;
  logic [15:0]   cnt;
  logic [15:0]   cnt_n;
  snap_t         snap;
  logic          pend;

  logic       ss_fall;
  logic       ss_rise;
  logic       sclk_rise;
  logic [3:0] bit_cnt;
  logic [7:0] rx;
  logic [7:0] rx_nxt;
  logic [7:0] rd_data;
  logic       cmd_end;
  logic       load;
  logic       commit;
  logic       wrap;
  logic       load_now;

  assign cmd_end  = (state == S_CMD) && sclk_rise && (bit_cnt == 4'd7);
  assign load     = cmd_end && rx_nxt[7];
  assign commit   = (state == S_DONE) && done_first;
  assign wrap     = NEMO_setup && (per_cnt == PER_MAX);
  assign cnt_n    = wrap ? cnt + 16'd1 : cnt;
  // A wrap seen during DATA is held until the frame leaves DATA.
  assign load_now = (wrap || pend) && (state != S_DATA);

`ifndef NEMO_WHOAMI_EN
  logic unused_whoami;
  assign unused_whoami = ^WHOAMI_VAL;
`endif

  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
`ifdef NEMO_WHOAMI_EN
      (rx_nxt[6:0] == A_WHOAMI): rd_data = WHOAMI_VAL;
`endif
      (rx_nxt[6:0] == A_INT_CFG): rd_data = int_cfg;
      (rx_nxt[6:0] == A_PTCH_L):  rd_data = snap.ptch[7:0];
      (rx_nxt[6:0] == A_PTCH_H):  rd_data = snap.ptch[15:8];
      (rx_nxt[6:0] == A_ROLL_L):  rd_data = snap.roll[7:0];
      (rx_nxt[6:0] == A_ROLL_H):  rd_data = snap.roll[15:8];
      (rx_nxt[6:0] == A_YAW_L):   rd_data = snap.yaw[7:0];
      (rx_nxt[6:0] == A_YAW_H):   rd_data = snap.yaw[15:8];
      (rx_nxt[6:0] == A_AX_L):    rd_data = snap.ax[7:0];
      (rx_nxt[6:0] == A_AX_H):    rd_data = snap.ax[15:8];
      (rx_nxt[6:0] == A_AY_L):    rd_data = snap.ay[7:0];
      (rx_nxt[6:0] == A_AY_H):    rd_data = snap.ay[15:8];
      default:                    rd_data = 8'h00;
    endcase
  end

  spi_serf_shift u_shift (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .load      (load),
    .load_data (rd_data),
    .tx_clr    ((state == S_IDLE) || (state == S_CMD)),
    .tx_act    (state == S_DATA),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .sclk_rise (sclk_rise),
    .bit_cnt   (bit_cnt),
    .rx        (rx),
    .rx_nxt    (rx_nxt),
    .miso      (MISO)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rw         <= 1'b0;
      addr       <= 7'h00;
      done_first <= 1'b0;
      int_cfg    <= 8'h00;
      NEMO_setup <= 1'b0;
      per_cnt    <= '0;
      cnt        <= 16'h0000;
      snap       <= '0;
      pend       <= 1'b0;
      INT        <= 1'b0;
    end else begin
      done_first <= 1'b0;
      if (ss_rise) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: if (ss_fall) state <= S_CMD;
          S_CMD: begin
            if (cmd_end) begin
              state <= S_DATA;
              rw    <= rx_nxt[7];
              addr  <= rx_nxt[6:0];
            end
          end
          S_DATA: begin
            if (sclk_rise && bit_cnt == 4'd15) begin
              state      <= S_DONE;
              done_first <= 1'b1;
            end
          end
          S_DONE: state <= S_DONE;
        endcase
      end

      if (commit && !rw && addr == A_INT_CFG) begin
        int_cfg    <= rx;
        NEMO_setup <= (rx == SETUP_VAL);
      end

      if (!NEMO_setup || wrap) per_cnt <= '0;
      else                     per_cnt <= per_cnt + 1'b1;
      if (wrap) cnt <= cnt + 16'd1;

      pend <= (wrap || pend) && (state == S_DATA);
      if (load_now) snap <= mk_snap(cnt_n);

      // Set beats clear when both land in the same clk.
      if (load_now) begin
        INT <= 1'b1;
      end else if (commit && rw && addr == A_AY_H) begin
        INT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_nemo_serf.sv
// Directed self-checking bench for spi_nemo_serf.
// Drives SPI mode-0 frames and checks registers, INT timing, aborts and reset.
module tb_spi_nemo_serf;

  localparam int P  = 4000;
  localparam int HP = 9;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;
  logic NEMO_setup;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_setup  = 0;
  int t_int    = 0;
  logic setup_q = 1'b0;
  logic int_q   = 1'b0;

  logic [7:0] rd;
  logic [7:0] whoami_exp;
  logic       bad;
  int         target;

  always #5 clk = ~clk;

  spi_nemo_serf #(
    .INT_PERIOD (P),
    .WHOAMI_VAL (8'h6A)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SS_n       (SS_n),
    .SCLK       (SCLK),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .INT        (INT),
    .NEMO_setup (NEMO_setup)
  );

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    setup_q <= NEMO_setup;
    int_q   <= INT;
    if (NEMO_setup && !setup_q) t_setup <= cyc;
    if (INT && !int_q)          t_int   <= cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] w, input int nr,
                      output logic [7:0] r);
    r = 8'h00;
    SS_n = 1'b0;
    tick(HP);
    for (int i = 0; i < nr; i++) begin
      MOSI = w[15-i];
      tick(HP);
      if (i >= 8) r[15-i] = MISO;
      SCLK = 1'b1;
      tick(HP);
      SCLK = 1'b0;
    end
    tick(HP);
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(12);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] w,
                        input logic [7:0] exp);
    logic [7:0] v;
    xfer(w, 16, v);
    chk(tag, 16'(v), 16'(exp));
  endtask

  task automatic wait_int(input string tag, input int budget);
    int k = 0;
    while (!INT && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 16'(INT), 16'h0001);
    tick(2);
  endtask

  initial begin
`ifdef NEMO_WHOAMI_EN
    whoami_exp = 8'h6A;
`else
    whoami_exp = 8'h00;
`endif
    rst  = 1'b1;
    SS_n = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    tick(5);
    chk("rst_miso",  16'(MISO), 16'h0);
    chk("rst_int",   16'(INT), 16'h0);
    chk("rst_setup", 16'(NEMO_setup), 16'h0);
    rst = 1'b0;
    tick(3);

    bad = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      tick(1);
      if (INT) bad = 1'b1;
    end
    chk("int_idle", 16'(bad), 16'h0);

    rd_chk("cfg_rst",  16'h8D00, 8'h00);
    rd_chk("whoami",   16'h8F00, whoami_exp);
    rd_chk("unmapped", 16'h9000, 8'h00);
    xfer(16'h2255, 16, rd);
    rd_chk("ro_write", 16'hA200, 8'h00);

    xfer(16'h0D02, 16, rd);
    chk("setup_on", 16'(NEMO_setup), 16'h1);
    wait_int("int_first", P + 100);
    chk("int_period",
        16'((t_int - t_setup >= P - 3) && (t_int - t_setup <= P + 3)),
        16'h1);

    rd_chk("ptch_l1", 16'hA200, 8'h01);
    rd_chk("ptch_h1", 16'hA300, 8'h00);
    rd_chk("roll_l1", 16'hA400, 8'hFE);
    rd_chk("roll_h1", 16'hA500, 8'hFF);
    rd_chk("yaw_l1",  16'hA600, 8'h02);
    rd_chk("ax_l1",   16'hA800, 8'h5B);
    rd_chk("ay_l1",   16'hAA00, 8'hFF);
    rd_chk("ay_h1",   16'hAB00, 8'hFF);
    chk("int_clr", 16'(INT), 16'h0);

    wait_int("int_second", P + 100);
    rd_chk("ay_h2", 16'hAB00, 8'hFF);
    chk("int_clr2", 16'(INT), 16'h0);
    target = t_int + P - 220;
    while (cyc < target) tick(1);
    rd_chk("ay_h_defer", 16'hAB00, 8'hFF);
    chk("int_set_wins", 16'(INT), 16'h1);
    rd_chk("ptch_l3", 16'hA200, 8'h03);

    xfer(16'h0D05, 10, rd);
    rd_chk("cfg_abort", 16'h8D00, 8'h02);
    chk("setup_abort", 16'(NEMO_setup), 16'h1);

    rd_chk("ay_h3", 16'hAB00, 8'hFF);
    chk("int_clr3", 16'(INT), 16'h0);
    force dut.cnt = 16'hFFFF;
    tick(2);
    release dut.cnt;
    wait_int("int_wrap", P + 100);
    rd_chk("ptch_l0", 16'hA200, 8'h00);
    rd_chk("ptch_h0", 16'hA300, 8'h00);
    rd_chk("roll_l0", 16'hA400, 8'hFF);
    rd_chk("roll_h0", 16'hA500, 8'hFF);
    rd_chk("ax_l0",   16'hA800, 8'h5A);
    rd_chk("ax_h0",   16'hA900, 8'h5A);
    rd_chk("ay_l0",   16'hAA00, 8'h00);
    rd_chk("ay_h0",   16'hAB00, 8'h00);

    xfer(16'h0D07, 16, rd);
    chk("setup_off", 16'(NEMO_setup), 16'h0);
    rd_chk("cfg_07", 16'h8D00, 8'h07);

    SS_n = 1'b0;
    tick(HP);
    for (int i = 0; i < 14; i++) begin
      MOSI = (i == 0 || i == 4 || i == 5 || i == 7) ? 1'b1 : 1'b0;
      tick(HP);
      SCLK = 1'b1;
      tick(HP);
      SCLK = 1'b0;
    end
    tick(HP);
    chk("miso_mid", 16'(MISO), 16'h1);
    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(3);
    chk("rst2_miso",  16'(MISO), 16'h0);
    chk("rst2_int",   16'(INT), 16'h0);
    chk("rst2_setup", 16'(NEMO_setup), 16'h0);
    rst = 1'b0;
    tick(5);
    rd_chk("cfg_rst2", 16'h8D00, 8'h00);
    xfer(16'h0D02, 16, rd);
    chk("setup_again", 16'(NEMO_setup), 16'h1);
    rd_chk("cfg_02", 16'h8D00, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_nemo_serf.md
SPI_NEMO_SERF -- requirements
Module: spi_nemo_serf

Interface
REQ-001 Parameter INT_PERIOD, default 50000, clk cycles between new-sample events once set up.
REQ-002 Parameter WHOAMI_VAL, default 8'h6A, value returned for a WHO_AM_I read.
REQ-003 Port clk  input  1  system clock. The block runs on this one clock; SCLK is sampled, not used as a clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port SS_n  input  1  SPI select, active-low, driven by the master.
REQ-006 Port SCLK  input  1  SPI clock, mode 0, idles low.
REQ-007 Port MOSI  input  1  SPI data from the master, MSB first.
REQ-008 Port MISO  output  1  SPI data to the master, MSB first.
REQ-009 Port INT  output  1  high when a new sample is ready.
REQ-010 Port NEMO_setup  output  1  high once 8'h02 has been written to INT_CFG.

Function
REQ-011 SS_n, SCLK and MOSI shall pass through 2-flop synchronizers; SCLK edges shall be detected from the synchronized signal, with rise/fall latency of 3 clk or less.
REQ-012 The master shall hold SCLK high and low for at least 8 clk each; behaviour with shorter phases is undefined.
REQ-013 Each frame is 16 bits, bounded by a synchronized SS_n fall and rise. MOSI is sampled on each SCLK rise. A bit counter counts 0..15.
REQ-014 Frame format: bit15 set means read, clear means write; bits[14:8] are the address; bits[7:0] are write data.
REQ-015 FSM states are IDLE, CMD (rises 1-8), DATA (rises 9-16) and DONE. SS_n fall moves IDLE to CMD. The 8th rise moves CMD to DATA. The 16th rise moves DATA to DONE. SS_n rise returns to IDLE from any state.
REQ-016 MISO shall be 0 in IDLE and CMD.
REQ-017 On the 8th rise of a read, the tx byte shall be loaded with the register data. Its MSB shall appear on MISO at the next SCLK fall, and the byte shall shift left on each later fall.
REQ-018 A write shall commit in DONE only. If SS_n rises before the 16th rise, the frame shall be discarded with no register change.
REQ-019 Register map:
  - 0x0F WHO_AM_I, read-only.
  - 0x0D INT_CFG, read/write.
  - 0x22..0x2B data registers, read-only, low byte at the even address: ptch, roll, yaw, ax, ay.
  - Reads of any other address return 8'h00; writes to them are ignored.
REQ-020 NEMO_setup shall rise in the clk after a committed write of 8'h02 to INT_CFG. Any other value written to INT_CFG shall clear it.
REQ-021 While NEMO_setup is high, a period counter shall count 0..INT_PERIOD-1 and wrap. At each wrap:
  - the 16-bit sample counter cnt increments, wrapping 16'hFFFF to 0;
  - the data snapshot is loaded with ptch=cnt, roll=~cnt, yaw=cnt<<1 (truncated to 16 bits), ax=cnt^16'h5A5A, ay=0-cnt (mod 2^16);
  - INT is set.
REQ-022 INT shall clear in the DONE of a read of 0x2B (ay high byte). If a wrap and that clear occur in the same clk, the set wins.
REQ-023 The snapshot shall not change while a frame is in DATA. A wrap during DATA shall defer the load and the INT set until DONE or IDLE.

Reset
REQ-024 While rst is asserted, everything shall clear:
  - outputs: MISO=0, INT=0, NEMO_setup=0;
  - state: FSM=IDLE, bit counter=0, tx/rx shift registers=0, INT_CFG=0;
  - counters and data: period counter=0, cnt=0, snapshot=0;
  - synchronizers: SS_n sync=1, SCLK sync=0.
REQ-025 If rst is asserted mid-frame, the frame shall be abandoned. After rst deasserts, the FSM shall wait in IDLE for a fresh SS_n fall.

Configuration
REQ-026 Macro NEMO_WHOAMI_EN: when defined, reading 0x0F returns WHOAMI_VAL. When undefined, 0x0F reads 8'h00 like an unmapped address.

Structure
REQ-027 Package nemo_pkg shall hold:
  - register address localparams;
  - the FSM state enum;
  - a snapshot struct of five 16-bit fields;
  - the INT_CFG setup constant 8'h02.
REQ-028 Sub-module spi_serf_shift shall contain the synchronizers, edge detection, bit counter and both shift registers. The top level holds the FSM, register file and sample generator.

Verification
REQ-029 After reset: MISO=0, INT=0, NEMO_setup=0, and INT stays 0 for 3*INT_PERIOD clk.
REQ-030 Write 16'h0D02 -> NEMO_setup=1. First INT after INT_PERIOD clk (±3). Then read 16'hA200/16'hA300 -> 8'h01/8'h00.
REQ-031 Read 16'h8F00 -> 8'h6A with NEMO_WHOAMI_EN defined; 8'h00 without it.
REQ-032 Read 16'hAB00 -> INT clears. Force INT wrap and clear in the same clk -> INT stays 1.
REQ-033 Abort a write to 0x0D after 10 rises -> INT_CFG unchanged. Assert rst mid-read -> all REQ-024 values; next full frame is correct.
REQ-034 Preload cnt to 16'hFFFF, one wrap -> cnt=0. Reads return ptch=16'h0000, roll=16'hFFFF, ax=16'h5A5A, ay=16'h0000.
